fft_mul_share_arb: RTL
======================

Name: fft_mul_share_arb

Overview:
- Shares one signed 16x8 -> 24-bit multiplier (the FFT twiddle multiplier datapath) among NUM_REQ butterfly lanes.
- Round-robin arbitration, valid/ready handshakes and a 2-stage registered pipeline around the combinational multiply.
- Each result returns tagged with its requester ID.
- Sits between the butterfly lane controllers and the single multiplier instance in the FFT core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, requester tag width; must be >= clog2(NUM_REQ).
- DIN0_WIDTH, 16, signed operand A width (data sample).
- DIN1_WIDTH, 8, signed operand B width (twiddle).
- DOUT_WIDTH, 24, signed product width (DIN0_WIDTH + DIN1_WIDTH).

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-lane request valid.
- req_a  in  NUM_REQ*DIN0_WIDTH  packed operand A; lane i at bits [i*16 +: 16].
- req_b  in  NUM_REQ*DIN1_WIDTH  packed operand B; lane i at bits [i*8 +: 8].
- req_ready  out  NUM_REQ  one-hot grant; a lane's transfer occurs when its valid and ready are both high.
- res_valid  out  1  result valid.
- res_prod  out  DOUT_WIDTH  signed product.
- res_id  out  ID_WIDTH  lane index of the result.
- res_ready  in  1  downstream accepts the result.
- busy  out  1  high when either pipeline stage holds data.

Behaviour:
- Reset: all outputs 0 (res_valid, res_prod, res_id, req_ready, busy). Both stage valids cleared. Round-robin pointer = 0, so lane 0 has highest priority first. Reset mid-operation discards in-flight data with no result emitted.
- Stage advance conditions:
  - s2_adv = !s2_valid || res_ready.
  - s1_adv = !s1_valid || s2_adv.
- Grant (combinational):
  - When s1_adv = 1, the first lane with req_valid set, scanning from pointer upward with wrap, gets req_ready = 1.
  - All other lanes get req_ready = 0.
  - When s1_adv = 0, req_ready = 0 for every lane.
  - req_ready never asserts for a lane whose req_valid is low; at most one bit is set.
- Accept:
  - The granted lane's A, B and ID are registered into stage 1; s1_valid = 1.
  - Pointer becomes (granted + 1) mod NUM_REQ.
  - With no accept, the pointer holds.
- Stage 1 -> stage 2: on s2_adv with s1_valid, register res_prod = $signed(A) * $signed(B) (full-precision, sign-extended to DOUT_WIDTH) and res_id; s2_valid = 1.
- Stage 1 bubble: if s2_adv and !s1_valid, s2_valid goes 0 once the current result is taken.
- Output: res_valid = s2_valid.
  - While res_valid && !res_ready, res_prod and res_id hold stable.
  - Both stages stall, and req_ready stays 0 once stage 1 is also full.
- Latency: accept at edge N, res_valid high after edge N+1. Throughput 1 result/cycle with res_ready held high.
- Simultaneous events: a stage 1 load and a stage 1 -> stage 2 move in the same cycle are legal. This is full pipelining with no bubble.
- Arithmetic boundaries:
  - -32768 * -128 = +4194304 (fits in 24 bits).
  - 32767 * 127 = 4161409.
  - No overflow possible at default widths.
- busy = s1_valid || s2_valid.

Optional Feature:
- FFT_MUL_ARB_ROUND_EN defined:
  - Stage 2 stores round-half-up(product / 2^7), i.e. (product + 64) >>> 7 arithmetic, sign-extended to DOUT_WIDTH (Q7 twiddle renormalisation).
  - +4194304 -> +32768; -64 -> 0; -65 -> -1.
  - Latency unchanged.
- Not defined: full-precision product as above.

Test Plan:
- Single lane: lane 2 requests A=1000, B=-3 with res_ready=1 -> req_ready[2]=1 at once; next cycle res_valid=1, res_prod=-3000, res_id=2.
- Round-robin fairness: all 4 lanes valid continuously, res_ready=1 -> grant order 0,1,2,3,0,1; results ordered likewise, one per cycle, no bubbles.
- Backpressure: fill the pipeline, hold res_ready=0 for 5 cycles -> res_prod/res_id stable, req_ready=0 after both stages are full; on release, two results drain on consecutive cycles with none lost or duplicated.
- Extremes: A=-32768, B=-128 -> res_prod=4194304; A=32767, B=-128 -> -4194176. With FFT_MUL_ARB_ROUND_EN: 32768 and -32767 respectively.
- Reset mid-stream: assert ap_rst with both stages full -> next cycle res_valid=0, busy=0, req_ready=0; first grant after reset goes to lane 0 when lanes 0 and 3 are both valid.
- Pointer hold: only lane 3 valid, accept, then lanes 0 and 1 valid -> lane 0 granted (pointer wrapped to 0), then lane 1.

Source files
------------

// File: rtl/fft_mul_share_arb.sv
// Round-robin share of one signed 16x8 multiplier among NUM_REQ lanes; accept->result 2 edges; stalls grants when both stages are full.
// Optional FFT_MUL_ARB_ROUND_EN: stage 2 keeps (product + 64) >>> 7 (Q7 twiddle renormalisation) instead of the full product.
module fft_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 24
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_b,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             res_valid,
  output logic [DOUT_WIDTH-1:0]            res_prod,
  output logic [ID_WIDTH-1:0]              res_id,
  input  logic                             res_ready,
  output logic                             busy
);

  logic                         s1_vld_q, s1_vld_d;
  logic signed [DIN0_WIDTH-1:0] s1_a_q, s1_a_d;
  logic signed [DIN1_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [ID_WIDTH-1:0]          s1_id_q, s1_id_d;
  logic                         s2_vld_q, s2_vld_d;
  logic signed [DOUT_WIDTH-1:0] s2_prod_q, s2_prod_d;
  logic [ID_WIDTH-1:0]          s2_id_q, s2_id_d;
  logic [ID_WIDTH-1:0]          ptr_q, ptr_d;

  logic                         s2_adv, s1_adv;
  logic                         gnt_vld;
  logic [ID_WIDTH-1:0]          gnt_idx;
  logic [ID_WIDTH-1:0]          scan_idx;
  logic signed [DOUT_WIDTH-1:0] prod_full;
  logic signed [DOUT_WIDTH-1:0] prod_st;
`ifdef FFT_MUL_ARB_ROUND_EN
  logic signed [DOUT_WIDTH:0]   rnd_sum;
`endif

  assign s2_adv = !s2_vld_q || res_ready;
  assign s1_adv = !s1_vld_q || s2_adv;

  // Scan from the pointer upward with wrap; first valid lane wins.
  always_comb begin
    req_ready = '0;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    if (s1_adv && !ap_rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
        if (!gnt_vld && req_valid[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    prod_full = DOUT_WIDTH'(s1_a_q) * DOUT_WIDTH'(s1_b_q);
`ifdef FFT_MUL_ARB_ROUND_EN
    rnd_sum = (DOUT_WIDTH+1)'(prod_full) + (DOUT_WIDTH+1)'(64);
    prod_st = DOUT_WIDTH'(rnd_sum >>> 7);
`else
    prod_st = prod_full;
`endif
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_id_d   = s1_id_q;
    s2_vld_d  = s2_vld_q;
    s2_prod_d = s2_prod_q;
    s2_id_d   = s2_id_q;
    ptr_d     = ptr_q;
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_prod_d = prod_st;
        s2_id_d   = s1_id_q;
      end
    end
    if (s1_adv) begin
      s1_vld_d = gnt_vld;
      if (gnt_vld) begin
        s1_a_d  = req_a[gnt_idx*DIN0_WIDTH +: DIN0_WIDTH];
        s1_b_d  = req_b[gnt_idx*DIN1_WIDTH +: DIN1_WIDTH];
        s1_id_d = gnt_idx;
        ptr_d   = (gnt_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_id_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_prod_q <= '0;
      s2_id_q   <= '0;
      ptr_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_id_q   <= s1_id_d;
      s2_vld_q  <= s2_vld_d;
      s2_prod_q <= s2_prod_d;
      s2_id_q   <= s2_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign res_valid = s2_vld_q;
  assign res_prod  = s2_prod_q;
  assign res_id    = s2_id_q;
  assign busy      = s1_vld_q || s2_vld_q;

endmodule
